// File: rtl/vx_dispatch_arbiter.sv
// Round-robin packet arbiter sharing one execute port among NUM_REQS requesters.
// A grant is held from the first accepted non-EOP beat until the holder's EOP beat fires.
module vx_dispatch_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 64,
    parameter int OUT_REG  = 0,
    parameter int IDX_W    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQS-1:0]       req_valid,
    input  logic [NUM_REQS*DATAW-1:0] req_data,
    input  logic [NUM_REQS-1:0]       req_sop,
    input  logic [NUM_REQS-1:0]       req_eop,
    output logic [NUM_REQS-1:0]       req_ready,
    output logic                      out_valid,
    output logic [DATAW-1:0]          out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [IDX_W-1:0]          out_idx,
    input  logic                      out_ready,
    output logic                      locked
);

    typedef enum logic { ST_IDLE = 1'b0, ST_LOCKED = 1'b1 } lock_st_e;

    lock_st_e         lock_st_q, lock_st_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

    logic             grant_any;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] scan_idx;
    logic             in_ready;
    logic             in_fire;
    logic             sel_valid;
    logic             sel_sop;
    logic             sel_eop;
    logic [DATAW-1:0] sel_data;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        if (lock_st_q == ST_LOCKED) begin
            grant_any = 1'b1;
            grant_idx = lock_idx_q;
        end else begin
            // Scan farthest-first so the valid requester nearest rr_ptr wins last.
            for (int k = NUM_REQS - 1; k >= 0; k--) begin
                scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQS);
                if (req_valid[scan_idx]) begin
                    grant_any = 1'b1;
                    grant_idx = scan_idx;
                end
            end
        end
    end

    assign sel_valid = grant_any & req_valid[grant_idx];
    assign sel_sop   = req_sop[grant_idx];
    assign sel_eop   = req_eop[grant_idx];
    assign sel_data  = req_data[int'(grant_idx) * DATAW +: DATAW];
    assign in_fire   = reset_n & sel_valid & in_ready;

    for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_ready
        assign req_ready[gi] = reset_n & grant_any & (int'(grant_idx) == gi) & in_ready;
    end

    always_comb begin
        lock_st_d  = lock_st_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        if (in_fire) begin
            if (sel_eop) begin
                lock_st_d = ST_IDLE;
                rr_ptr_d  = IDX_W'((int'(grant_idx) + 1) % NUM_REQS);
            end else begin
                lock_st_d  = ST_LOCKED;
                lock_idx_d = grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_st_q  <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            lock_st_q  <= lock_st_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign locked = (lock_st_q == ST_LOCKED);

    if (OUT_REG == 0) begin : g_comb_out
        assign in_ready  = out_ready;
        assign out_valid = reset_n & sel_valid;
        assign out_data  = sel_data;
        assign out_sop   = sel_sop;
        assign out_eop   = sel_eop;
        assign out_idx   = grant_idx;
    end else begin : g_skid_out
        localparam int PW = DATAW + 2 + IDX_W;

        logic [PW-1:0] mem_q [2];
        logic          wr_ptr_q;
        logic          rd_ptr_q;
        logic [1:0]    count_q;
        logic          pop;

        // Ready depends only on occupancy, keeping out_ready off the req_ready path.
        assign in_ready  = (count_q != 2'd2);
        assign out_valid = (count_q != 2'd0);
        assign pop       = out_valid & out_ready;

        always_ff @(posedge clk) begin
            if (in_fire) begin
                mem_q[wr_ptr_q] <= {sel_data, sel_sop, sel_eop, grant_idx};
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                count_q  <= 2'd0;
            end else begin
                if (in_fire) wr_ptr_q <= ~wr_ptr_q;
                if (pop)     rd_ptr_q <= ~rd_ptr_q;
                case ({in_fire, pop})
                    2'b10:   count_q <= count_q + 2'd1;
                    2'b01:   count_q <= count_q - 2'd1;
                    default: count_q <= count_q;
                endcase
            end
        end

        assign {out_data, out_sop, out_eop, out_idx} = mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_vx_dispatch_arbiter.sv
// Directed bench for vx_dispatch_arbiter: three instances (4 req comb, 3 req skid, 1 req)
// with an in-order scoreboard of expected output beats per instance.
module tb_vx_dispatch_arbiter;

    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [3:0]      v4, s4, e4, r4;
    logic [4*DW-1:0] d4;
    logic            ov4, os4, oe4, ordy4, lk4;
    logic [DW-1:0]   od4;
    logic [1:0]      oi4;

    logic [2:0]      v3, s3, e3, r3;
    logic [3*DW-1:0] d3;
    logic            ov3, os3, oe3, ordy3, lk3;
    logic [DW-1:0]   od3;
    logic [1:0]      oi3;

    logic [0:0]      v1, s1, e1, r1;
    logic [DW-1:0]   d1;
    logic            ov1, os1, oe1, ordy1, lk1;
    logic [DW-1:0]   od1;
    logic [0:0]      oi1;

    int checks = 0;
    int errors = 0;
    logic [31:0] q4[$];
    logic [31:0] q3[$];
    logic [31:0] q1[$];

    vx_dispatch_arbiter #(.NUM_REQS(4), .DATAW(DW), .OUT_REG(0)) u4 (
        .clk(clk), .reset_n(reset_n), .req_valid(v4), .req_data(d4), .req_sop(s4),
        .req_eop(e4), .req_ready(r4), .out_valid(ov4), .out_data(od4), .out_sop(os4),
        .out_eop(oe4), .out_idx(oi4), .out_ready(ordy4), .locked(lk4));

    vx_dispatch_arbiter #(.NUM_REQS(3), .DATAW(DW), .OUT_REG(1)) u3 (
        .clk(clk), .reset_n(reset_n), .req_valid(v3), .req_data(d3), .req_sop(s3),
        .req_eop(e3), .req_ready(r3), .out_valid(ov3), .out_data(od3), .out_sop(os3),
        .out_eop(oe3), .out_idx(oi3), .out_ready(ordy3), .locked(lk3));

    vx_dispatch_arbiter #(.NUM_REQS(1), .DATAW(DW), .OUT_REG(0)) u1 (
        .clk(clk), .reset_n(reset_n), .req_valid(v1), .req_data(d1), .req_sop(s1),
        .req_eop(e1), .req_ready(r1), .out_valid(ov1), .out_data(od1), .out_sop(os1),
        .out_eop(oe1), .out_idx(oi1), .out_ready(ordy1), .locked(lk1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int idx, input logic s, input logic e,
                                       input logic [DW-1:0] d);
        return {12'd0, 2'(idx), s, e, d};
    endfunction

    function automatic logic [DW-1:0] dat(input int i, input int n);
        return {4'(i), 12'(n)};
    endfunction

    task automatic mon_all();
        logic [31:0] exp;
        if (ov4 && ordy4) begin
            chk("sb4_expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                exp = q4.pop_front();
                chk("sb4_beat", pk(int'(oi4), os4, oe4, od4), exp);
            end
        end
        if (ov3 && ordy3) begin
            chk("sb3_expected", 32'(q3.size() != 0), 32'd1);
            if (q3.size() != 0) begin
                exp = q3.pop_front();
                chk("sb3_beat", pk(int'(oi3), os3, oe3, od3), exp);
            end
        end
        if (ov1 && ordy1) begin
            chk("sb1_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                exp = q1.pop_front();
                chk("sb1_beat", pk(int'(oi1), os1, oe1, od1), exp);
            end
        end
    endtask

    task automatic mid();
        @(negedge clk);
        mon_all();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic set4(input int n);
        for (int i = 0; i < 4; i++) d4[i*DW +: DW] = dat(i, n);
    endtask

    task automatic set3(input int n);
        for (int i = 0; i < 3; i++) d3[i*DW +: DW] = dat(i, n);
    endtask

    initial begin
        reset_n = 1'b0;
        v4 = '0; s4 = '0; e4 = '0; d4 = '0; ordy4 = 1'b0;
        v3 = '0; s3 = '0; e3 = '0; d3 = '0; ordy3 = 1'b0;
        v1 = '0; s1 = '0; e1 = '0; d1 = '0; ordy1 = 1'b0;

        // Reset with traffic present: ready and valid forced low
        v4 = 4'hF; s4 = 4'hF; e4 = 4'hF; ordy4 = 1'b1; set4(0);
        mid();
        chk("rst_ready4", 32'(r4), 32'h0);
        chk("rst_valid4", 32'(ov4), 32'h0);
        adv();
        mid();
        adv();
        reset_n = 1'b1;
        v4 = '0;
        mid();
        chk("rst_locked4", 32'(lk4), 32'h0);
        chk("rst_locked3", 32'(lk3), 32'h0);
        chk("rst_locked1", 32'(lk1), 32'h0);
        chk("rst_valid3", 32'(ov3), 32'h0);
        adv();

        // Round-robin over four always-valid single-beat requesters
        for (int n = 0; n < 8; n++) begin
            v4 = 4'hF; s4 = 4'hF; e4 = 4'hF; set4(n);
            q4.push_back(pk(n % 4, 1'b1, 1'b1, dat(n % 4, n)));
            mid();
            chk("rr_ready", 32'(r4), 32'(1) << (n % 4));
            chk("rr_locked", 32'(lk4), 32'h0);
            adv();
        end

        // Move rr_ptr to 2 with a lone beat from requester 1
        v4 = 4'b0010; s4 = 4'b0010; e4 = 4'b0010; set4(20);
        q4.push_back(pk(1, 1'b1, 1'b1, dat(1, 20)));
        mid();
        chk("pre_lock_ready", 32'(r4), 32'h2);
        adv();

        // Requester 2: 3-beat instruction with a 2-cycle gap; 0 and 1 always valid
        v4 = 4'b0111; s4 = 4'b0111; e4 = 4'b0011; set4(30);
        q4.push_back(pk(2, 1'b1, 1'b0, dat(2, 30)));
        mid();
        chk("lock_b1_ready", 32'(r4), 32'h4);
        chk("lock_b1_locked", 32'(lk4), 32'h0);
        adv();
        for (int g = 0; g < 2; g++) begin
            v4 = 4'b0011;
            mid();
            chk("lock_gap_ready", 32'(r4), 32'h4);
            chk("lock_gap_valid", 32'(ov4), 32'h0);
            chk("lock_gap_locked", 32'(lk4), 32'h1);
            adv();
        end
        v4 = 4'b0111; s4 = 4'b0011; e4 = 4'b0011; set4(31);
        q4.push_back(pk(2, 1'b0, 1'b0, dat(2, 31)));
        mid();
        chk("lock_b2_ready", 32'(r4), 32'h4);
        chk("lock_b2_locked", 32'(lk4), 32'h1);
        adv();
        e4 = 4'b0111; set4(32);
        q4.push_back(pk(2, 1'b0, 1'b1, dat(2, 32)));
        mid();
        chk("lock_b3_locked", 32'(lk4), 32'h1);
        adv();
        // Requester 3 idle, so the grant wraps to 0
        v4 = 4'b0011; s4 = 4'b0011; e4 = 4'b0011; set4(33);
        q4.push_back(pk(0, 1'b1, 1'b1, dat(0, 33)));
        mid();
        chk("post_lock_ready", 32'(r4), 32'h1);
        chk("post_lock_locked", 32'(lk4), 32'h0);
        adv();

        // Reset while requester 1 holds the lock
        v4 = 4'b0010; s4 = 4'b0010; e4 = 4'b0000; set4(40);
        q4.push_back(pk(1, 1'b1, 1'b0, dat(1, 40)));
        mid();
        adv();
        reset_n = 1'b0;
        v4 = 4'b0001; s4 = 4'b0001; e4 = 4'b0001;
        mid();
        chk("rstmid_locked_before", 32'(lk4), 32'h1);
        chk("rstmid_ready", 32'(r4), 32'h0);
        chk("rstmid_valid", 32'(ov4), 32'h0);
        adv();
        reset_n = 1'b1;
        v4 = 4'b0011; s4 = 4'b0011; e4 = 4'b0011; set4(41);
        q4.push_back(pk(0, 1'b1, 1'b1, dat(0, 41)));
        mid();
        chk("rstmid_locked_after", 32'(lk4), 32'h0);
        chk("rstmid_grant0", 32'(r4), 32'h1);
        chk("rstmid_skid_empty", 32'(ov3), 32'h0);
        adv();
        v4 = '0;

        // NUM_REQS=3 wrap: requester 2 wins, next grant goes to 0
        ordy3 = 1'b1;
        v3 = 3'b100; s3 = 3'b111; e3 = 3'b111; set3(50);
        q3.push_back(pk(2, 1'b1, 1'b1, dat(2, 50)));
        mid();
        chk("wrap_ready2", 32'(r3), 32'h4);
        adv();
        v3 = 3'b011; set3(51);
        q3.push_back(pk(0, 1'b1, 1'b1, dat(0, 51)));
        mid();
        chk("wrap_ready0", 32'(r3), 32'h1);
        chk("wrap_out_valid", 32'(ov3), 32'h1);
        adv();
        v3 = '0;
        mid();
        adv();

        // Backpressure: out_ready low for 4 cycles, only two beats fit
        ordy3 = 1'b0;
        v3 = 3'b111; s3 = 3'b111; e3 = 3'b101; set3(60);
        q3.push_back(pk(1, 1'b1, 1'b0, dat(1, 60)));
        mid();
        chk("bp_ready_b1", 32'(r3), 32'h2);
        adv();
        s3 = 3'b101; e3 = 3'b111; set3(61);
        q3.push_back(pk(1, 1'b0, 1'b1, dat(1, 61)));
        mid();
        chk("bp_ready_b2", 32'(r3), 32'h2);
        chk("bp_locked", 32'(lk3), 32'h1);
        adv();
        for (int c = 0; c < 2; c++) begin
            mid();
            chk("bp_full_ready", 32'(r3), 32'h0);
            chk("bp_full_valid", 32'(ov3), 32'h1);
            adv();
        end
        ordy3 = 1'b1;
        mid();
        chk("bp_release_ready", 32'(r3), 32'h0);
        adv();
        v3 = '0;
        mid();
        adv();
        mid();
        chk("bp_drained", 32'(ov3), 32'h0);
        adv();

        // Single requester: 2-beat instruction
        ordy1 = 1'b1;
        v1 = 1'b1; s1 = 1'b1; e1 = 1'b0; d1 = dat(0, 70);
        q1.push_back(pk(0, 1'b1, 1'b0, dat(0, 70)));
        mid();
        chk("one_ready", 32'(r1), 32'h1);
        chk("one_locked_b1", 32'(lk1), 32'h0);
        adv();
        s1 = 1'b0; e1 = 1'b1; d1 = dat(0, 71);
        q1.push_back(pk(0, 1'b0, 1'b1, dat(0, 71)));
        mid();
        chk("one_locked_b2", 32'(lk1), 32'h1);
        adv();
        v1 = 1'b0;
        mid();
        chk("one_locked_after", 32'(lk1), 32'h0);
        adv();

        chk("sb4_left", 32'(q4.size()), 32'h0);
        chk("sb3_left", 32'(q3.size()), 32'h0);
        chk("sb1_left", 32'(q1.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vx_dispatch_arbiter.md
# vx_dispatch_arbiter

Round-robin packet arbiter that shares one execute port among `NUM_REQS` dispatch requesters. A requester's transfer can span several beats, which are the SOP…EOP packets of one instruction split across lane blocks. Once a requester is granted, the arbiter holds the grant until its EOP beat is accepted, so packets of different instructions never interleave on the shared port. It sits between the per-issue-slot dispatch queues and a single execute unit input, such as a shared SFU or tensor block.

## Interface

**Parameters**
- `NUM_REQS`, 4: number of requesters; any value ≥1, need not be a power of 2.
- `DATAW`, 64: payload width per beat.
- `OUT_REG`, 0: 0 = combinational pass-through; 1 = 2-entry registered skid buffer on the output.
- `IDX_W`, `LOG2UP(NUM_REQS)`: derived; grantee index width.

**Ports**
- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in NUM_REQS: per-requester beat valid.
- `req_data` in NUM_REQS×DATAW: per-requester payload.
- `req_sop` in NUM_REQS: beat is the first packet of its instruction.
- `req_eop` in NUM_REQS: beat is the last packet of its instruction.
- `req_ready` out NUM_REQS: beat accepted from requester i when `req_valid[i] & req_ready[i]`.
- `out_valid` out 1: output beat valid.
- `out_data` out DATAW: payload of the granted beat.
- `out_sop` out 1: forwarded SOP.
- `out_eop` out 1: forwarded EOP.
- `out_idx` out IDX_W: index of the requester that sourced the beat.
- `out_ready` in 1: downstream accept.
- `locked` out 1: arbiter is mid-instruction, with SOP accepted and EOP still pending.

## Operation

**State**
- `rr_ptr` (IDX_W): highest-priority requester.
- `lock_st`: IDLE or LOCKED.
- `lock_idx` (IDX_W): holder of the grant while LOCKED.

**IDLE**
- Grant goes to the first `i` with `req_valid[i]` = 1, scanning `rr_ptr`, `rr_ptr+1`, … mod `NUM_REQS`.
- If no requester is valid, there is no grant.

**LOCKED**
- Grant is `lock_idx` only, whether or not it is valid.
- All other `req_ready` are 0.
- If the holder drops `req_valid`, the port idles. The lock is kept.

**Input fire and state transitions** (input fire = `req_valid[g] & req_ready[g]` for the grantee g)
- Fire with `req_eop[g]` = 1: go to IDLE and set `rr_ptr` = (g+1) mod `NUM_REQS`. Wrap at `NUM_REQS`, not at 2^IDX_W.
- Fire with `req_eop[g]` = 0: go to LOCKED and set `lock_idx` = g. `rr_ptr` is unchanged.
- A single-beat instruction (SOP and EOP both 1) never enters LOCKED.

**Data path and protocol**
- SOP is forwarded but not checked. Lock is driven by EOP only.
- `out_idx` = g; `out_data`, `out_sop`, `out_eop` come from requester g.
- `NUM_REQS` = 1: `rr_ptr` and `lock_idx` are constant 0. Locking still drives `locked`.
- `req_ready[i]` = `grant[i] & in_ready`.
  - OUT_REG=0: `in_ready` = `out_ready`.
  - OUT_REG=1: `in_ready` = skid buffer not full.
- OUT_REG=1 buffer: 2-entry FIFO of {data, sop, eop, idx}.
  - `out_valid` = not empty; output comes from the head.
  - A simultaneous push and pop when full is not allowed, because `in_ready` = 0 then.
  - A simultaneous push and pop with 1 entry keeps the count at 1.

## Timing

**Reset** (`reset_n` = 0 at a `clk` edge)
- `rr_ptr` = 0, state IDLE, `locked` = 0.
- Skid buffer empty, so `out_valid` = 0 when OUT_REG=1.
- With OUT_REG=0, outputs are combinational from inputs. During reset, `req_ready` = 0 and `out_valid` = 0 are forced.
- Reset asserted mid-instruction drops the lock and any buffered beats. Nothing is replayed.

**Latency**
- OUT_REG=0: 0 cycles from input to output.
- OUT_REG=1: 1 cycle; a beat accepted at edge N is visible at `out_*` after edge N.
- Throughput is 1 beat/cycle in both modes while `out_ready` = 1.

**Update timing**
- `locked` is registered and reflects the state after the last edge.
- Grant is combinational from the current state and `req_valid`.
- `rr_ptr` and lock update on the same edge as the input fire.
- No combinational path from `out_ready` to `req_ready` when OUT_REG=1.

## Test plan

1. **Round-robin order.** NUM_REQS=4; all four requesters continuously offer single-beat (SOP=EOP=1) beats; `out_ready`=1 → `out_idx` sequence is 0,1,2,3,0,1…, one beat per cycle, `locked` stays 0.
2. **Lock holds across a stall.** Requester 2 sends a 3-beat instruction with a 2-cycle `req_valid` gap after beat 1; requesters 0 and 1 valid throughout → `out_idx`=2 for all 3 beats, `req_ready[0:1]`=0 throughout, `locked`=1 until beat 3 fires, next grant goes to 3 if valid, else wraps to 0.
3. **Non-power-of-2 wrap.** NUM_REQS=3; requester 2 wins with an EOP beat → `rr_ptr`=0, never 3; next grant goes to 0 when 0 and 1 are both valid.
4. **Backpressure.** OUT_REG=1, `out_ready`=0 for 4 cycles → exactly 2 beats accepted, then all `req_ready`=0; on release the beats drain in order with the correct `out_idx`/`out_sop`/`out_eop`, with no loss or duplication.
5. **Reset mid-instruction.** Requester 1 is locked after beat 1 of 4; assert `reset_n`=0 for 1 cycle → next cycle `locked`=0, `out_valid`=0, `rr_ptr`=0; requester 0 is granted first if valid.
6. **Single requester.** NUM_REQS=1; 2-beat instruction → `out_idx`=0 both beats, `locked`=1 between them and 0 after EOP.
